// File: rtl/minibyte_bus_responder_pkg.sv
// Shared definitions for the minibyte bus responder.
//   - Address map constants (external window, scratch RAM, register offsets)
//   - Status register bit indices
//   - Bus FSM state encoding and address-region encoding
//   - Default external-access timeout
//   - decode_addr(): maps a CPU address onto its region
package minibyte_bus_responder_pkg;

  localparam int unsigned ExtTimeoutDefault = 15;

  // Address map
  localparam logic [7:0] ExtLast      = 8'hDF;
  localparam logic [7:0] RamBase      = 8'hE0;
  localparam logic [7:0] RamLast      = 8'hEF;
  localparam logic [7:0] RegGpioOut   = 8'hF0;
  localparam logic [7:0] RegGpioIn    = 8'hF1;
  localparam logic [7:0] RegTimer     = 8'hF2;
  localparam logic [7:0] RegStatus    = 8'hF3;

  // Status/control register bits
  localparam int unsigned StatEnBit      = 0;
  localparam int unsigned StatWrapBit    = 1;
  localparam int unsigned StatTimeoutBit = 7;

  // Value returned to the CPU when an external access times out
  localparam logic [7:0] HoldTimeoutVal = 8'hFF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StExtWait = 2'd1,
    StExtDone = 2'd2
  } bus_state_e;

  typedef enum logic [2:0] {
    RegionExt     = 3'd0,
    RegionRam     = 3'd1,
    RegionGpioOut = 3'd2,
    RegionGpioIn  = 3'd3,
    RegionTimer   = 3'd4,
    RegionStatus  = 3'd5,
    RegionNone    = 3'd6
  } region_e;

  function automatic region_e decode_addr(input logic [7:0] addr);
    region_e region;
    if (addr <= ExtLast) begin
      region = RegionExt;
    end else if (addr <= RamLast) begin
      region = RegionRam;
    end else begin
      case (addr)
        RegGpioOut: region = RegionGpioOut;
        RegGpioIn:  region = RegionGpioIn;
        RegTimer:   region = RegionTimer;
        RegStatus:  region = RegionStatus;
        default:    region = RegionNone;
      endcase
    end
    return region;
  endfunction

endpackage

// File: rtl/minibyte_bus_responder_timer8.sv
// minibyte_timer8: 8-bit up-counter with synchronous load.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset (count -> 0x00)
//   enable         : increment by one on this edge
//   load           : load load_value on this edge (takes priority over enable)
//   load_value     : value written by load
//   count          : current count
//   wrap           : combinational pulse, high in the cycle whose edge wraps 0xFF -> 0x00
module minibyte_timer8 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] count,
  output logic       wrap
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  // A load on the wrapping edge suppresses the wrap: the CPU value wins.
  assign wrap  = enable && !load && (count_q == 8'hFF);
  assign count = count_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/minibyte_bus_responder.sv
// minibyte_bus_responder: CPU-side bus responder for an 8-bit address space.
//   0x00-0xDF external memory (stalling handshake), 0xE0-0xEF scratch RAM,
//   0xF0 GPIO out, 0xF1 GPIO in (synchronized), 0xF2 timer, 0xF3 status/control,
//   0xF4-0xFF read as zero.
// Ports:
//   clk_in, rst_in, ena_in          : clock, async active-high reset, global enable
//   addr_in, data_in, we_in,
//   drive_in, data_out, halt_out    : CPU bus (data_out is zero-wait for internal regions)
//   ext_req, ext_addr, ext_rdata,
//   ext_ack, ext_we, ext_wdata      : external memory handshake (ext_wdata = data_in)
//   gpio_in, gpio_out               : asynchronous inputs, registered outputs
module minibyte_bus_responder
  import minibyte_bus_responder_pkg::*;
#(
  parameter int unsigned EXT_TIMEOUT = ExtTimeoutDefault
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ena_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       we_in,
  input  logic       drive_in,
  output logic [7:0] data_out,
  output logic       halt_out,
  output logic       ext_req,
  output logic [7:0] ext_addr,
  input  logic [7:0] ext_rdata,
  input  logic       ext_ack,
  output logic       ext_we,
  output logic [7:0] ext_wdata,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam int unsigned ToW = (EXT_TIMEOUT > 1) ? $clog2(EXT_TIMEOUT) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(EXT_TIMEOUT - 1);

  region_e        region;
  bus_state_e     state_q;
  logic [7:0]     hold_q;
  logic [ToW-1:0] to_cnt_q;
  logic           timeout_hit;

  logic [7:0] ram_q [16];
  logic [7:0] gpio_out_q;
  logic [7:0] gpio_meta_q;
  logic [7:0] gpio_sync_q;
  logic       ctrl_en_q;
  logic       wrap_flag_q;
  logic       timeout_flag_q;

  logic       wr_int;
  logic       timer_load;
  logic       timer_wrap;
  logic [7:0] timer_count;

  assign region = decode_addr(addr_in);
  assign wr_int = ena_in && we_in && drive_in;

  // ---------------------------------------------------------------------------
  // External access FSM
  // ---------------------------------------------------------------------------
  // Last permitted wait cycle without an ack; an ack in that cycle still wins.
  assign timeout_hit = ena_in && (state_q == StExtWait) && !ext_ack && (to_cnt_q == ToLast);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      hold_q   <= 8'h00;
      to_cnt_q <= '0;
    end else if (ena_in) begin
      unique case (state_q)
        StIdle: begin
          to_cnt_q <= '0;
          if (region == RegionExt) begin
            state_q <= StExtWait;
          end
        end
        StExtWait: begin
          if (ext_ack) begin
            // Write acks carry no data; keep the hold register untouched.
            if (!we_in) begin
              hold_q <= ext_rdata;
            end
            state_q <= StExtDone;
          end else if (to_cnt_q == ToLast) begin
            hold_q  <= HoldTimeoutVal;
            state_q <= StExtDone;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StExtDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ext_req  = 1'b0;
    halt_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ena_in && (region == RegionExt)) begin
          ext_req  = 1'b1;
          halt_out = 1'b1;
        end
      end
      StExtWait: begin
        ext_req  = 1'b1;
        halt_out = 1'b1;
      end
      StExtDone: begin
        ext_req  = 1'b0;
        halt_out = 1'b0;
      end
      default: begin
        ext_req  = 1'b0;
        halt_out = 1'b0;
      end
    endcase
    // Drop the handshake the moment reset rises, not just after state clears.
    if (rst_in) begin
      ext_req  = 1'b0;
      halt_out = 1'b0;
    end
  end

  assign ext_addr  = addr_in;
  assign ext_wdata = data_in;
  assign ext_we    = ext_req && we_in && drive_in;

  // ---------------------------------------------------------------------------
  // Scratch RAM (contents are not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (wr_int && (region == RegionRam)) begin
      ram_q[addr_in[3:0]] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // GPIO: output register and two-flop input synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gpio_out_q  <= 8'h00;
      gpio_meta_q <= 8'h00;
      gpio_sync_q <= 8'h00;
    end else begin
      gpio_meta_q <= gpio_in;
      gpio_sync_q <= gpio_meta_q;
      if (wr_int && (region == RegionGpioOut)) begin
        gpio_out_q <= data_in;
      end
    end
  end

  assign gpio_out = gpio_out_q;

  // ---------------------------------------------------------------------------
  // Timer and status/control
  // ---------------------------------------------------------------------------
  assign timer_load = wr_int && (region == RegionTimer);

  minibyte_timer8 u_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .enable     (ena_in && ctrl_en_q),
    .load       (timer_load),
    .load_value (data_in),
    .count      (timer_count),
    .wrap       (timer_wrap)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ctrl_en_q      <= 1'b0;
      wrap_flag_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      // Set terms are ORed after the clear so a coincident event keeps the flag.
      if (wr_int && (region == RegionStatus)) begin
        ctrl_en_q      <= data_in[StatEnBit];
        wrap_flag_q    <= (wrap_flag_q && !data_in[StatWrapBit]) || timer_wrap;
        timeout_flag_q <= (timeout_flag_q && !data_in[StatTimeoutBit]) || timeout_hit;
      end else begin
        wrap_flag_q    <= wrap_flag_q || timer_wrap;
        timeout_flag_q <= timeout_flag_q || timeout_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CPU read data
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out = 8'h00;
    if (state_q == StExtDone) begin
      data_out = hold_q;
    end else begin
      unique case (region)
        RegionRam:     data_out = ram_q[addr_in[3:0]];
        RegionGpioOut: data_out = gpio_out_q;
        RegionGpioIn:  data_out = gpio_sync_q;
        RegionTimer:   data_out = timer_count;
        RegionStatus:  data_out = {timeout_flag_q, 5'b00000, wrap_flag_q, ctrl_en_q};
        default:       data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_bus_responder.sv
module tb_minibyte_bus_responder;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       ena_in;
  logic [7:0] addr_in;
  logic [7:0] data_in;
  logic       we_in;
  logic       drive_in;
  logic [7:0] data_out;
  logic       halt_out;
  logic       ext_req;
  logic [7:0] ext_addr;
  logic [7:0] ext_rdata;
  logic       ext_ack;
  logic       ext_we;
  logic [7:0] ext_wdata;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  minibyte_bus_responder dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .ena_in    (ena_in),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .we_in     (we_in),
    .drive_in  (drive_in),
    .data_out  (data_out),
    .halt_out  (halt_out),
    .ext_req   (ext_req),
    .ext_addr  (ext_addr),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .ext_we    (ext_we),
    .ext_wdata (ext_wdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Apply a bus cycle and let combinational outputs settle.
  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic w);
    addr_in = a;
    data_in = d;
    we_in   = w;
    #1;
  endtask

  initial begin
    rst_in = 1'b1; ena_in = 1'b0; addr_in = 8'hE0; data_in = 8'h00; we_in = 1'b0;
    drive_in = 1'b1; ext_rdata = 8'h00; ext_ack = 1'b0; gpio_in = 8'h00;
    #1;
    check("rst_halt", {7'd0, halt_out}, 8'h00);
    check("rst_ext_req", {7'd0, ext_req}, 8'h00);
    tick(); tick();
    rst_in = 1'b0;
    bus(8'hF0, 8'h00, 1'b0);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_rd_f0", data_out, 8'h00);
    bus(8'hF2, 8'h00, 1'b0); check("rst_timer", data_out, 8'h00);
    bus(8'hF3, 8'h00, 1'b0); check("rst_status", data_out, 8'h00);
    bus(8'hF1, 8'h00, 1'b0); check("rst_gpio_in", data_out, 8'h00);

    // RAM write then zero-wait read
    ena_in = 1'b1;
    bus(8'hE3, 8'h5A, 1'b1);
    tick();
    bus(8'hE3, 8'h00, 1'b0);
    check("ram_rd_5a", data_out, 8'h5A);
    check("ram_rd_halt", {7'd0, halt_out}, 8'h00);
    // Same-cycle write/read returns old data
    bus(8'hE3, 8'hA7, 1'b1);
    check("ram_rdw_old", data_out, 8'h5A);
    tick();
    bus(8'hE3, 8'h00, 1'b0);
    check("ram_rdw_new", data_out, 8'hA7);
    // drive_in low blocks the write
    drive_in = 1'b0;
    bus(8'hE3, 8'h11, 1'b1);
    tick();
    drive_in = 1'b1;
    bus(8'hE3, 8'h00, 1'b0);
    check("ram_no_drive", data_out, 8'hA7);

    // GPIO out
    bus(8'hF0, 8'h3C, 1'b1);
    tick();
    bus(8'hF0, 8'h00, 1'b0);
    check("gpio_out", gpio_out, 8'h3C);
    check("gpio_out_rd", data_out, 8'h3C);

    // External read, ack in third wait cycle: halt for 4 cycles
    bus(8'h10, 8'h00, 1'b0);
    check("ext_c0_halt", {7'd0, halt_out}, 8'h01);
    check("ext_c0_req", {7'd0, ext_req}, 8'h01);
    check("ext_addr", ext_addr, 8'h10);
    tick();
    check("ext_c1_halt", {7'd0, halt_out}, 8'h01);
    tick();
    check("ext_c2_halt", {7'd0, halt_out}, 8'h01);
    tick();
    ext_ack = 1'b1; ext_rdata = 8'hC3; #1;
    check("ext_c3_halt", {7'd0, halt_out}, 8'h01);
    check("ext_c3_req", {7'd0, ext_req}, 8'h01);
    tick();
    ext_ack = 1'b0; ext_rdata = 8'h00; #1;
    check("ext_done_halt", {7'd0, halt_out}, 8'h00);
    check("ext_done_req", {7'd0, ext_req}, 8'h00);
    check("ext_done_data", data_out, 8'hC3);
    bus(8'hE3, 8'h00, 1'b0);
    tick();
    check("ext_back_idle", data_out, 8'hA7);

    // External write: data forwarded, rdata ignored
    bus(8'h40, 8'h99, 1'b1);
    check("extw_we", {7'd0, ext_we}, 8'h01);
    check("extw_wdata", ext_wdata, 8'h99);
    tick();
    ext_ack = 1'b1; ext_rdata = 8'h66; #1;
    tick();
    ext_ack = 1'b0; #1;
    check("extw_done_halt", {7'd0, halt_out}, 8'h00);
    check("extw_hold_kept", data_out, 8'hC3);
    bus(8'hE0, 8'h00, 1'b0);
    tick();

    // External read with no ack: timeout after 15 wait cycles
    bus(8'h20, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("to_wait15_halt", {7'd0, halt_out}, 8'h01);
    tick();
    check("to_done_halt", {7'd0, halt_out}, 8'h00);
    check("to_done_data", data_out, 8'hFF);
    bus(8'hF3, 8'h00, 1'b0);
    tick();
    check("to_status", data_out, 8'h80);
    bus(8'hF3, 8'h80, 1'b1);
    tick();
    bus(8'hF3, 8'h00, 1'b0);
    check("to_w1c", data_out, 8'h00);

    // ena_in low: no stall in IDLE
    ena_in = 1'b0;
    bus(8'h30, 8'h00, 1'b0);
    check("ena0_halt", {7'd0, halt_out}, 8'h00);
    tick();
    check("ena0_frozen", {7'd0, halt_out}, 8'h00);
    ena_in = 1'b1;

    // Timer wrap
    bus(8'hF2, 8'hFE, 1'b1);
    tick();
    bus(8'hF3, 8'h01, 1'b1);
    tick();
    bus(8'hF2, 8'h00, 1'b0);
    check("tmr_fe", data_out, 8'hFE);
    tick(); tick();
    check("tmr_wrap_cnt", data_out, 8'h00);
    bus(8'hF3, 8'h00, 1'b0);
    check("tmr_wrap_stat", data_out, 8'h03);
    // Freeze with ena_in low
    ena_in = 1'b0;
    bus(8'hF2, 8'h00, 1'b0);
    tick();
    check("tmr_frozen", data_out, 8'h00);
    ena_in = 1'b1;
    tick();
    check("tmr_resume", data_out, 8'h01);
    // CPU load beats increment
    bus(8'hF2, 8'h55, 1'b1);
    tick();
    bus(8'hF2, 8'h00, 1'b0);
    check("tmr_load_wins", data_out, 8'h55);
    // Wrap coincident with W1C keeps flag set
    bus(8'hF2, 8'hFF, 1'b1);
    tick();
    bus(8'hF3, 8'h03, 1'b1);
    tick();
    bus(8'hF3, 8'h00, 1'b0);
    check("tmr_w1c_coinc", data_out, 8'h03);
    bus(8'hF3, 8'h02, 1'b1);
    tick();
    bus(8'hF3, 8'h00, 1'b0);
    check("tmr_w1c_clear", data_out, 8'h00);

    // GPIO input synchronizer: two-cycle latency
    gpio_in = 8'hA5;
    bus(8'hF1, 8'h00, 1'b0);
    check("gpio_in_c0", data_out, 8'h00);
    tick();
    check("gpio_in_c1", data_out, 8'h00);
    tick();
    check("gpio_in_c2", data_out, 8'hA5);

    // Unmapped registers
    bus(8'hF8, 8'h77, 1'b1);
    tick();
    bus(8'hF8, 8'h00, 1'b0);
    check("unmapped_f8", data_out, 8'h00);
    bus(8'hFF, 8'h00, 1'b0);
    check("unmapped_ff", data_out, 8'h00);

    // Reset in the middle of EXT_WAIT (timer running again to expose reset)
    bus(8'hF3, 8'h01, 1'b1);
    tick();
    bus(8'h30, 8'h00, 1'b0);
    tick();
    check("rstw_halt_pre", {7'd0, halt_out}, 8'h01);
    rst_in = 1'b1;
    #1;
    check("rstw_req", {7'd0, ext_req}, 8'h00);
    check("rstw_halt", {7'd0, halt_out}, 8'h00);
    check("rstw_gpio_out", gpio_out, 8'h00);
    bus(8'hF3, 8'h00, 1'b0); check("rstw_status", data_out, 8'h00);
    bus(8'hF2, 8'h00, 1'b0); check("rstw_timer", data_out, 8'h00);
    bus(8'hF1, 8'h00, 1'b0); check("rstw_gpio_sync", data_out, 8'h00);
    tick();
    rst_in = 1'b0;
    #1;
    check("rstw_after_idle", {7'd0, halt_out}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minibyte_bus_responder.md
MINIBYTE_BUS_RESPONDER -- requirements
Module: minibyte_bus_responder

Interface
REQ-001 SHALL have parameter EXT_TIMEOUT, default 15, max wait cycles for ext_ack before forced completion.
REQ-002 SHALL have ports: clk_in input 1 clock; rst_in input 1 reset, asynchronous, active-high; ena_in input 1 global enable.
REQ-003 SHALL have CPU-side ports: addr_in in 8, data_in in 8 (CPU write data), we_in in 1, drive_in in 1, data_out out 8 (CPU read data), halt_out out 1 (stall request).
REQ-004 SHALL have external-memory ports: ext_req out 1, ext_addr out 8, ext_rdata in 8, ext_ack in 1.
REQ-005 SHALL have IO ports: gpio_in in 8 (asynchronous), gpio_out out 8.

Function
REQ-006 SHALL decode: 0x00-0xDF external; 0xE0-0xEF 16x8 scratch RAM; 0xF0 GPIO out (RW); 0xF1 GPIO in (RO); 0xF2 timer count (RW); 0xF3 status/control (RW); 0xF4-0xFF read 0x00, writes ignored.
REQ-007 SHALL drive data_out combinationally from addr_in for internal regions (zero-wait read, same cycle).
REQ-008 SHALL perform internal writes on the rising edge when ena_in=1, we_in=1, drive_in=1.
REQ-009 SHALL implement FSM IDLE, EXT_WAIT, EXT_DONE for external accesses.
REQ-010 IDLE: external address with ena_in=1 -> halt_out=1 and ext_req=1 combinationally, next state EXT_WAIT.
REQ-011 EXT_WAIT: hold ext_req=1, halt_out=1, ext_addr=addr_in; on ext_ack=1 capture ext_rdata into hold register, next EXT_DONE.
REQ-012 EXT_WAIT: if EXT_TIMEOUT cycles elapse without ext_ack, load hold register with 0xFF, set status bit7 (timeout error), next EXT_DONE.
REQ-013 EXT_DONE: halt_out=0, ext_req=0, data_out=hold register, unconditional return to IDLE; total external read latency = ack cycle + 1.
REQ-014 External writes SHALL use the same handshake; ext_rdata is ignored, data_in is forwarded externally unchanged.
REQ-015 ena_in=0 SHALL freeze FSM, timer and timeout counter; halt_out=0 in IDLE.
REQ-016 GPIO in SHALL pass a 2-flop synchronizer; reads at 0xF1 return the synchronized value (2-cycle latency).
REQ-017 Timer: 8-bit up-counter, increments each ena_in cycle while control bit0=1; wraps 0xFF->0x00 and sets sticky bit1.
REQ-018 Status 0xF3: bit0 enable (RW), bit1 wrap flag and bit7 timeout flag (write-1-to-clear), other bits read 0.
REQ-019 A CPU write to 0xF2 in the same cycle as an increment SHALL win; flag set coincident with W1C SHALL leave the flag set.
REQ-020 RAM write and read of the same address in one cycle SHALL return the old data (write takes effect at the edge).

Reset
REQ-021 rst_in SHALL asynchronously force: FSM IDLE, hold reg 0x00, timeout counter 0, gpio_out 0x00, timer 0x00, status 0x00, synchronizer flops 0.
REQ-022 Reset mid-EXT_WAIT SHALL drop ext_req and halt_out immediately; RAM contents need not reset.

Structure
REQ-023 Shared package SHALL hold the address-map constants (region bases, register offsets), status bit indices, FSM state encoding, and the EXT_TIMEOUT default.
REQ-024 The timer SHALL be one sub-module, minibyte_timer8 (count, enable, load, wrap pulse).

Verification
REQ-025 Write 0x5A to 0xE3, read 0xE3 -> data_out=0x5A same cycle, halt_out=0.
REQ-026 Read 0x10, ext_ack after 3 cycles with ext_rdata=0xC3 -> halt_out high 4 cycles, data_out=0xC3 in EXT_DONE.
REQ-027 Read 0x20 with no ext_ack -> after 15 cycles data_out=0xFF, 0xF3 reads 0x80; write 0x80 to 0xF3 -> reads 0x00.
REQ-028 Write 0xFE to 0xF2, 0x01 to 0xF3 -> after 2 cycles count=0x00, 0xF3 reads 0x03.
REQ-029 gpio_in=0xA5 -> 0xF1 reads 0xA5 after 2 cycles, not before.
REQ-030 Assert rst_in in EXT_WAIT -> ext_req=0, halt_out=0 before the next edge; all registers at reset values.
